// File: rtl/otter_io_pkg.sv
// Shared definitions for the OTTER IOBUS timer/LED/switch responder:
// register offsets, CTRL bit positions and the timer state encoding.
package otter_io_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_LOAD   = 8'h04;
    localparam logic [7:0] OFF_COUNT  = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_LEDS   = 8'h10;
    localparam logic [7:0] OFF_SW     = 8'h14;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IRQ  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for asynchronous board inputs; both stages clear on reset.
module io_sync2 #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/otter_iobus_timer.sv
// IOBUS responder: prescaled countdown timer driving INTR, an LED register
// and synchronised switches, all in one 256-byte window at BASE_ADDR.
module otter_iobus_timer
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          PRESCALE  = 100,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    output logic [31:0]      IOBUS_IN,
    input  logic [SW_W-1:0]  SWITCHES,
    output logic [LED_W-1:0] LEDS,
    output logic             INTR
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [2:0]       r_ctrl;
    logic [31:0]      r_load;
    logic [31:0]      r_count;
    logic             r_status;
    logic [LED_W-1:0] r_leds;
    logic             r_intr;
    logic [15:0]      r_presc;
    timer_state_t     r_state;
    timer_state_t     w_next;

    logic             w_hit;
    logic [7:0]       w_off;
    logic             w_we;
    logic             w_wr_ctrl, w_wr_load, w_wr_status, w_wr_leds;
    logic             w_stop;
    logic             w_run;
    logic             w_tick;
    logic             w_step;
    logic             w_expire;
    logic [SW_W-1:0]  w_sw;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_hit    = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
    assign w_off    = {IOBUS_ADDR[7:2], 2'b00};
    assign w_unused = ^IOBUS_ADDR[1:0];
    assign w_we     = IOBUS_WR & w_hit;

    assign w_wr_ctrl   = w_we & (w_off == OFF_CTRL);
    assign w_wr_load   = w_we & (w_off == OFF_LOAD);
    assign w_wr_status = w_we & (w_off == OFF_STATUS);
    assign w_wr_leds   = w_we & (w_off == OFF_LEDS);
    assign w_stop      = w_wr_ctrl & ~IOBUS_OUT[CTRL_EN];

    // A LOAD write or a disable on the tick cycle suppresses all timer action.
    assign w_tick   = w_run & (r_presc == PRE_MAX);
    assign w_step   = w_tick & ~w_wr_load & ~w_stop;
    assign w_expire = w_step & (r_count == '0);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_ctrl[CTRL_EN]) w_next = RUN;
            RUN:     if (w_expire && !r_ctrl[CTRL_AUTO]) w_next = DONE;
            DONE:    if (w_wr_load && r_ctrl[CTRL_EN]) w_next = RUN;
            default: w_next = IDLE;
        endcase
        if (w_stop) w_next = IDLE;
    end

    always_comb begin
        w_run = (r_state == RUN);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_presc <= '0;
        end else if (!w_run || w_wr_load || w_stop || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ctrl   <= '0;
            r_load   <= '0;
            r_count  <= '0;
            r_status <= 1'b0;
            r_leds   <= '0;
            r_intr   <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= IOBUS_OUT[2:0];
            if (w_wr_leds) r_leds <= IOBUS_OUT[LED_W-1:0];

            if (w_wr_load) begin
                r_load  <= IOBUS_OUT;
                r_count <= IOBUS_OUT;
            end else if (w_step) begin
                if (r_count != '0)          r_count <= r_count - 32'd1;
                else if (r_ctrl[CTRL_AUTO]) r_count <= r_load;
            end

            if (w_expire)                         r_status <= 1'b1;
            else if (w_wr_status && IOBUS_OUT[0]) r_status <= 1'b0;

            r_intr <= r_status & r_ctrl[CTRL_IRQ];
        end
    end

    io_sync2 #(.W(SW_W)) u_sw_sync (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_d     (SWITCHES),
        .o_q     (w_sw)
    );

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_off)
                OFF_CTRL:   w_rdata = {29'd0, r_ctrl};
                OFF_LOAD:   w_rdata = r_load;
                OFF_COUNT:  w_rdata = r_count;
                OFF_STATUS: w_rdata = {31'd0, r_status};
                OFF_LEDS:   w_rdata = 32'(r_leds);
                OFF_SW:     w_rdata = 32'(w_sw);
                default:    w_rdata = '0;
            endcase
        end
    end

    assign IOBUS_IN = w_rdata;
    assign LEDS     = r_leds;
    assign INTR     = r_intr;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Bench for otter_iobus_timer: directed timing/priority cases plus randomized
// timer and bus traffic checked against an arithmetic model of the timer.
module tb_otter_iobus_timer;

    localparam logic [31:0] BASE = 32'h1100_0000;
    localparam int          P    = 2;
    localparam logic [31:0] A_CTRL = BASE | 32'h00;
    localparam logic [31:0] A_LOAD = BASE | 32'h04;
    localparam logic [31:0] A_CNT  = BASE | 32'h08;
    localparam logic [31:0] A_STAT = BASE | 32'h0C;
    localparam logic [31:0] A_LED  = BASE | 32'h10;
    localparam logic [31:0] A_SW   = BASE | 32'h14;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_IN;
    logic [15:0] SWITCHES = '0;
    logic [15:0] LEDS;
    logic        INTR;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    otter_iobus_timer #(
        .BASE_ADDR (BASE),
        .PRESCALE  (P),
        .LED_W     (16),
        .SW_W      (16)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .SWITCHES   (SWITCHES),
        .LEDS       (LEDS),
        .INTR       (INTR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    // Write lands on the next rising edge; returns just after that edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(posedge CLK);
        #1;
        IOBUS_WR  = 1'b0;
        IOBUS_OUT = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_WR   = 1'b0;
        #1;
        d = IOBUS_IN;
    endtask

    // t = edges since RUN was entered; a tick every P edges, reload after LOAD+1 ticks.
    function automatic logic [31:0] exp_count(input int l, input int au, input int t);
        int n;
        n = t / P;
        if (n <= l) return 32'(l - n);
        if (au == 0) return 32'd0;
        return 32'(l - (n % (l + 1)));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, d, a;
        logic [15:0] led_m, sw;
        int run0, te, ti, t, l, au, irq;

        // power-on reset
        #1;
        chk("por_leds", 32'(LEDS), 0);
        chk("por_intr", 32'(INTR), 0);
        repeat (2) step();
        RESET_N = 1'b1;
        step();
        rd(A_CTRL, r); chk("por_ctrl", r, 0);
        rd(A_LOAD, r); chk("por_load", r, 0);
        rd(A_CNT,  r); chk("por_count", r, 0);
        rd(A_STAT, r); chk("por_status", r, 0);
        rd(A_LED,  r); chk("por_led_rd", r, 0);
        rd(A_SW,   r); chk("por_sw", r, 0);

        // decode
        wr(A_LED, 32'hFFFF_A5A5);
        step();
        chk("led_port", 32'(LEDS), 32'h0000_A5A5);
        rd(A_LED, r); chk("led_rd_zext", r, 32'h0000_A5A5);
        wr(32'h1200_0010, 32'h0000_1111);
        step();
        chk("led_miss", 32'(LEDS), 32'h0000_A5A5);
        rd(BASE | 32'h18, r); chk("unmapped_18", r, 0);
        wr(A_LOAD, 32'h55);
        wr(A_CNT, 32'hDEAD_BEEF);
        step();
        rd(A_CNT, r); chk("count_ro", r, 32'h55);
        rd(32'h1200_0004, r); chk("miss_rd", r, 0);

        // switch synchroniser latency
        step();
        SWITCHES = 16'h00F0;
        run0 = cyc;
        goto(run0 + 1);
        rd(A_SW, r); chk("sw_edge1", r, 0);
        goto(run0 + 2);
        rd(A_SW, r); chk("sw_edge2", r, 32'h0000_00F0);

        // one-shot, LOAD=3: expire 8 edges after RUN entry, INTR one later
        wr(A_CTRL, 0); wr(A_STAT, 1); wr(A_LOAD, 3); wr(A_CTRL, 32'h5);
        run0 = cyc + 1;
        te = -1; ti = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            rd(A_STAT, r);
            if (r[0] && te < 0) te = cyc - run0;
            if (INTR && ti < 0) ti = cyc - run0;
        end
        chk("oneshot_exp_t", 32'(te), 8);
        chk("oneshot_intr_t", 32'(ti), 9);
        rd(A_CNT, r); chk("oneshot_count0", r, 0);
        wr(A_STAT, 1);
        repeat (12) step();
        rd(A_STAT, r); chk("done_no_reexp", r, 0);
        chk("done_intr_low", 32'(INTR), 0);
        rd(A_CNT, r); chk("done_count0", r, 0);
        // LOAD write in DONE with EN=1 restarts the countdown
        wr(A_LOAD, 1);
        run0 = cyc;
        goto(run0 + 3);
        rd(A_STAT, r); chk("done_reload_pre", r, 0);
        goto(run0 + 4);
        rd(A_STAT, r); chk("done_reload_exp", r, 1);

        // auto-reload LOAD=1: expire every 4 edges
        wr(A_CTRL, 0); wr(A_STAT, 1); wr(A_LOAD, 1); wr(A_CTRL, 32'h7);
        run0 = cyc + 1;
        goto(run0 + 3);
        rd(A_STAT, r); chk("auto_pre", r, 0);
        goto(run0 + 4);
        rd(A_STAT, r); chk("auto_exp1", r, 1);
        chk("auto_intr_lag", 32'(INTR), 0);
        goto(run0 + 5);
        chk("auto_intr1", 32'(INTR), 1);
        wr(A_STAT, 1);                      // lands on run0+6
        rd(A_STAT, r); chk("clr_status", r, 0);
        chk("clr_intr_hold", 32'(INTR), 1);
        goto(run0 + 7);
        chk("clr_intr_drop", 32'(INTR), 0);
        goto(run0 + 8);
        rd(A_STAT, r); chk("auto_exp2", r, 1);
        goto(run0 + 9);
        chk("auto_intr2", 32'(INTR), 1);
        wr(A_STAT, 1);                      // lands on run0+10
        rd(A_STAT, r); chk("clr2_status", r, 0);
        goto(run0 + 11);
        wr(A_STAT, 1);                      // lands on expire edge run0+12
        rd(A_STAT, r); chk("set_beats_clr", r, 1);
        goto(run0 + 13);
        wr(A_LOAD, 9);                      // lands on tick edge run0+14
        rd(A_CNT, r); chk("load_beats_tick", r, 9);
        goto(run0 + 16);
        rd(A_CNT, r); chk("load_restart", r, 8);
        wr(A_LOAD, 0);                      // lands on run0+17, ticks now on odd edges
        goto(run0 + 19);
        rd(A_STAT, r); chk("load0_exp", r, 1);
        wr(A_STAT, 1);                      // lands on run0+20
        wr(A_CTRL, 32'h6);                  // EN=0 on tick edge run0+21
        rd(A_STAT, r); chk("stop_beats_tick", r, 0);
        repeat (6) step();
        rd(A_STAT, r); chk("idle_no_exp", r, 0);

        // randomized timer runs against the arithmetic model
        for (int it = 0; it < 8; it++) begin
            l   = $urandom_range(0, 5);
            au  = $urandom_range(0, 1);
            irq = $urandom_range(0, 1);
            wr(A_CTRL, 0); wr(A_STAT, 1); wr(A_LOAD, 32'(l));
            wr(A_CTRL, 32'(irq * 4 + au * 2 + 1));
            run0 = cyc + 1;
            for (int k = 0; k < 8; k++) begin
                repeat ($urandom_range(1, 4)) step();
                t = cyc - run0;
                rd(A_CNT, r);  chk("rnd_count", r, exp_count(l, au, t));
                rd(A_STAT, r); chk("rnd_status", r, (t >= (l + 1) * P) ? 32'd1 : 32'd0);
                chk("rnd_intr", 32'(INTR), (irq != 0 && t >= (l + 1) * P + 1) ? 32'd1 : 32'd0);
            end
        end

        // randomized bus traffic
        led_m = LEDS;
        for (int i = 0; i < 12; i++) begin
            d = $urandom;
            wr(A_LED | 32'($urandom_range(0, 3)), d);
            led_m = d[15:0];
            a = $urandom;
            if (a[31:8] == BASE[31:8]) a[31] = ~a[31];
            a[7:0] = 8'h10;
            wr(a, $urandom);
            step();
            chk("rnd_led_port", 32'(LEDS), 32'(led_m));
            rd(A_LED, r); chk("rnd_led_rd", r, 32'(led_m));
            d = $urandom;
            wr(A_CTRL, d);
            rd(A_CTRL, r); chk("rnd_ctrl_rd", r, d & 32'h7);
            d = $urandom;
            wr(A_LOAD, d);
            rd(A_LOAD, r); chk("rnd_load_rd", r, d);
            rd(BASE | 32'($urandom_range(6, 63) * 4), r); chk("rnd_unmapped", r, 0);
            step();
            sw = 16'($urandom);
            SWITCHES = sw;
            step(); step();
            rd(A_SW, r); chk("rnd_sw", r, 32'(sw));
        end

        // asynchronous reset mid-RUN
        wr(A_LED, 32'h1234);
        wr(A_CTRL, 0); wr(A_STAT, 1); wr(A_LOAD, 0); wr(A_CTRL, 32'h7);
        repeat (6) step();
        wr(A_LOAD, 5);
        step();
        rd(A_CNT, r); chk("pre_rst_count", r, 5);
        chk("pre_rst_intr", 32'(INTR), 1);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("rst_leds", 32'(LEDS), 0);
        chk("rst_intr", 32'(INTR), 0);
        rd(A_CNT,  r); chk("rst_count", r, 0);
        rd(A_CTRL, r); chk("rst_ctrl", r, 0);
        rd(A_STAT, r); chk("rst_status", r, 0);
        rd(A_LOAD, r); chk("rst_load", r, 0);
        rd(A_SW,   r); chk("rst_sw", r, 0);
        step();
        RESET_N = 1'b1;
        repeat (4) step();
        rd(A_CNT, r); chk("post_rst_idle", r, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
